// File: rtl/reg_bank_arb.sv
// ---------------------------------------------------------------------------
// reg_bank_arb
//   Four-requester round-robin arbiter in front of a shared flop bank. It
//   multiplexes one write per cycle into the bank and sequences multi-cycle
//   bank clears. Every output comes straight from a register.
//
//   Optional feature: define ARB_LOCK_EN to compile in burst locking. With
//   it, a grantee holding lock+req is regranted back-to-back for up to
//   MAX_BURST consecutive writes. Without it, lock is ignored.
//
// Parameters
//   WIDTH       bank word width
//   CLR_CYCLES  cycles bank_clear_n is held low per clear (1..15)
//   MAX_BURST   max consecutive locked grants to one requester (1..15)
//
// Ports
//   clk           sole clock, rising edge
//   reset         synchronous, active-high reset
//   req[3:0]      per-requester write request, held until own gnt is seen
//   wr_data       requester i data at [i*WIDTH +: WIDTH]
//   clr_req       single-cycle clear request pulse
//   lock[3:0]     per-requester burst lock (ARB_LOCK_EN builds only)
//   gnt[3:0]      one-hot grant, high in the cycle the write hits the bank
//   bank_in       data presented to the bank
//   bank_enable   bank load enable
//   bank_clear_n  bank clear, active low
//   busy          high while in WRITE or CLEAR
//   clr_done      one-cycle pulse in the first cycle after a clear
// ---------------------------------------------------------------------------
module reg_bank_arb #(
    parameter int WIDTH      = 8,
    parameter int CLR_CYCLES = 2,
    parameter int MAX_BURST  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] wr_data,
    input  logic               clr_req,
    input  logic [3:0]         lock,
    output logic [3:0]         gnt,
    output logic [WIDTH-1:0]   bank_in,
    output logic               bank_enable,
    output logic               bank_clear_n,
    output logic               busy,
    output logic               clr_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         gnt_q, gnt_d;
    logic [WIDTH-1:0]   bank_in_q, bank_in_d;
    logic               bank_en_q, bank_en_d;
    logic               clr_n_q, clr_n_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pend_q, pend_d;
    logic [1:0]         last_q, last_d;
    logic [3:0]         cnt_q, cnt_d;

    logic [3:0][WIDTH-1:0] wd_arr;
    logic [3:0]         mreq;
    logic               hold;
    logic               win_vld;
    logic [1:0]         win_idx;
    logic               wr_fire;

    assign wd_arr = wr_data;

    // The requester being written this cycle is masked so the request it
    // is still holding up cannot produce a second write.
    assign mreq = req & ~gnt_q;

    // -----------------------------------------------------------------------
    // Burst lock
    // -----------------------------------------------------------------------
`ifdef ARB_LOCK_EN
    logic [3:0] burst_q, burst_d;

    // The current grantee keeps the bank while it holds lock+req and has not
    // yet used up its burst. Once the burst is exhausted the normal mask
    // above removes it, which forces rotation.
    assign hold = (state_q == S_WRITE) && gnt_q[last_q] && lock[last_q] &&
                  req[last_q] && (burst_q < 4'(MAX_BURST));

    always_comb begin
        burst_d = 4'd0;
        if (wr_fire) begin
            burst_d = hold ? burst_q + 4'd1 : 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            burst_q <= 4'd0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    logic lock_unused;
    assign lock_unused = ^lock;
    assign hold        = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Round-robin pick: search from last_q+1 around to last_q itself.
    // -----------------------------------------------------------------------
    always_comb begin
        logic [1:0] cand;
        win_vld = 1'b0;
        win_idx = last_q;
        cand    = last_q;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!win_vld && mreq[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
        if (hold) begin
            win_vld = 1'b1;
            win_idx = last_q;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and registered-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        gnt_d     = 4'b0000;
        bank_in_d = bank_in_q;
        bank_en_d = 1'b0;
        done_d    = 1'b0;
        pend_d    = pend_q | clr_req;
        last_d    = last_q;
        cnt_d     = cnt_q;
        wr_fire   = 1'b0;

        case (state_q)
            S_CLEAR: begin
                // A clr_req seen here stays in pend_d and starts another
                // full clear from IDLE right after this one.
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                // A pending clear wins over any request. The write presented
                // this cycle (if any) still completes, since it is already on
                // the bank outputs. last_q is left alone so rotation resumes
                // where it stopped.
                if (pend_q || clr_req) begin
                    state_d = S_CLEAR;
                    pend_d  = 1'b0;
                    cnt_d   = 4'(CLR_CYCLES - 1);
                end else if (win_vld) begin
                    state_d   = S_WRITE;
                    gnt_d     = 4'b0001 << win_idx;
                    bank_en_d = 1'b1;
                    bank_in_d = wd_arr[win_idx];
                    last_d    = win_idx;
                    wr_fire   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase

        clr_n_d = (state_d != S_CLEAR);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            gnt_q     <= 4'b0000;
            bank_in_q <= '0;
            bank_en_q <= 1'b0;
            clr_n_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pend_q    <= 1'b0;
            last_q    <= 2'd3;
            cnt_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            bank_in_q <= bank_in_d;
            bank_en_q <= bank_en_d;
            clr_n_q   <= clr_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pend_q    <= pend_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt          = gnt_q;
    assign bank_in      = bank_in_q;
    assign bank_enable  = bank_en_q;
    assign bank_clear_n = clr_n_q;
    assign busy         = busy_q;
    assign clr_done     = done_q;

endmodule

// File: doc/reg_bank_arb.md
REG_BANK_ARB -- requirements
Module: reg_bank_arb

Interface
REQ-001 Parameter WIDTH, default 8, width of shared register bank word.
REQ-002 Parameter CLR_CYCLES, default 2, cycles bank_clear_n held low per clear (legal 1..15).
REQ-003 Parameter MAX_BURST, default 4, max consecutive locked grants to one requester (legal 1..15).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  4  per-requester write request; held high with data until own gnt bit seen.
REQ-007 wr_data  input  4*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
REQ-008 clr_req  input  1  single-cycle pulse requesting bank clear.
REQ-009 lock  input  4  per-requester burst lock (used only with ARB_LOCK_EN).
REQ-010 gnt  output  4  one-hot grant/ack; high exactly in cycle the write is presented to bank.
REQ-011 bank_in  output  WIDTH  data to shared flop bank.
REQ-012 bank_enable  output  1  bank load enable.
REQ-013 bank_clear_n  output  1  bank clear, active-low.
REQ-014 busy  output  1  high in WRITE or CLEAR state.
REQ-015 clr_done  output  1  one-cycle pulse after clear completes.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 States: IDLE, WRITE, CLEAR; FSM SHALL change state only on clk rising edge.
REQ-018 Arbitration each cycle in IDLE or WRITE; req sampled in cycle N -> gnt/bank_enable/bank_in in cycle N+1.
REQ-019 Round-robin: search starts at (last_grantee+1) mod 4; last_grantee resets to 3 (requester 0 first).
REQ-020 req bit of the requester whose gnt is high in the current cycle SHALL be masked from that cycle's arbitration (no double write).
REQ-021 Grant present -> WRITE: gnt one-hot, bank_enable=1, bank_in=grantee's wr_data, bank_clear_n=1.
REQ-022 No unmasked req and no pending clear -> IDLE: gnt=0, bank_enable=0, bank_in holds last value.
REQ-023 clr_req SHALL set clr_pending; clr_pending beats any req at next arbitration; a WRITE in progress completes first.
REQ-024 CLEAR: bank_clear_n=0, bank_enable=0, gnt=0 for exactly CLR_CYCLES cycles, then IDLE; clr_done high the first cycle after; clr_pending cleared on CLEAR entry.
REQ-025 clr_req during CLEAR SHALL be latched and cause a second full CLEAR after the first.
REQ-026 clr_req and req arriving in the same cycle: CLEAR first, grant afterward; last_grantee unchanged by CLEAR.
REQ-027 Back-to-back grants SHALL incur no idle cycles while unmasked requests exist.

Reset
REQ-028 reset high SHALL override everything at next edge, including mid-WRITE and mid-CLEAR.
REQ-029 Reset values: state=IDLE, gnt=0, bank_in=0, bank_enable=0, bank_clear_n=1, busy=0, clr_done=0, clr_pending=0, last_grantee=3, burst count=0.

Configuration
REQ-030 Macro ARB_LOCK_EN compiles in burst locking.
REQ-031 With ARB_LOCK_EN: grantee with lock and req high while gnt high SHALL be regranted next cycle (REQ-020 mask bypassed) until lock drops or MAX_BURST consecutive grants, then forced rotation; clr_pending still ends the burst after the current write.
REQ-032 Without ARB_LOCK_EN: lock ignored, no burst counter logic, strict REQ-020 behaviour.

Verification
REQ-033 Reset, req=4'b1111 held, each requester drops req after own gnt -> gnt 0001,0010,0100,1000 on four consecutive cycles, bank_enable high all four.
REQ-034 Only req[2], wr_data[2]=8'hA5 -> one cycle later gnt=0100, bank_in=8'hA5, bank_enable=1; requester re-asserts next cycle -> regranted after one masked cycle, no double write.
REQ-035 clr_req pulse while req[0] pending, CLR_CYCLES=2 -> bank_clear_n low 2 cycles, gnt=0 throughout, clr_done pulse, then gnt=0001.
REQ-036 reset asserted in second CLEAR cycle -> next cycle bank_clear_n=1, busy=0, all outputs at reset values, pending clear dropped.
REQ-037 ARB_LOCK_EN, MAX_BURST=4, req[1] and lock[1] held, req[3] held -> gnt=0010 four cycles, then 1000; without macro gnt alternates 0010/1000.
